// File: rtl/vend_pkg.sv
// Shared definitions for the vending dispense controller: FSM encoding,
// event bit positions and default parameter values.
package vend_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_VEND  = 3'd1,
        ST_CHG10 = 3'd2,
        ST_CHG5  = 3'd3,
        ST_FAULT = 3'd4
    } vend_state_t;

    localparam int EVT_W   = 3;
    localparam int EVT_OUT = 2;
    localparam int EVT_C10 = 1;
    localparam int EVT_C5  = 0;

    localparam int DEF_QDEPTH        = 4;
    localparam int DEF_HOPPER_CYCLES = 4;
    localparam int DEF_MOTOR_TIMEOUT = 64;
    localparam int DEF_CNT_W         = 16;

    // First actuator phase for a freshly popped entry (entries are never zero).
    function automatic vend_state_t first_state(input logic [EVT_W-1:0] evt);
        vend_state_t st;
        if (evt[EVT_OUT]) begin
            st = ST_VEND;
        end else if (evt[EVT_C10]) begin
            st = ST_CHG10;
        end else begin
            st = ST_CHG5;
        end
        return st;
    endfunction

    function automatic vend_state_t after_vend(input logic [EVT_W-1:0] evt);
        vend_state_t st;
        if (evt[EVT_C10]) begin
            st = ST_CHG10;
        end else if (evt[EVT_C5]) begin
            st = ST_CHG5;
        end else begin
            st = ST_IDLE;
        end
        return st;
    endfunction

endpackage

// File: rtl/vend_evt_fifo.sv
// Small synchronous event FIFO. Head data is read combinationally; the
// caller qualifies push/pop so full/empty are never violated.
module vend_evt_fifo
    import vend_pkg::*;
#(
    parameter int DEPTH = DEF_QDEPTH,
    parameter int W     = EVT_W,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  logic [W-1:0]  i_wdata,
    input  logic          i_pop,
    output logic [W-1:0]  o_rdata,
    output logic          o_full,
    output logic          o_empty,
    output logic [AW:0]   o_count
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    // Storage needs no reset: occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/vend_dispense_ctrl.sv
// Turns vend/change pulses into timed motor and hopper commands, buffering
// events in a FIFO, counting sales and latching fault/overflow status.
module vend_dispense_ctrl
    import vend_pkg::*;
#(
    parameter int QDEPTH        = DEF_QDEPTH,
    parameter int HOPPER_CYCLES = DEF_HOPPER_CYCLES,
    parameter int MOTOR_TIMEOUT = DEF_MOTOR_TIMEOUT,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             out,
    input  logic             change5,
    input  logic             change10,
    input  logic             motor_done,
    output logic             motor_en,
    output logic             hopper5,
    output logic             hopper10,
    output logic             busy,
    output logic             overflow,
    output logic             fault,
    output logic [CNT_W-1:0] sales_cnt,
    output vend_state_t      dbg_state
);

    localparam int AW   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int TMAX = (MOTOR_TIMEOUT > HOPPER_CYCLES) ? MOTOR_TIMEOUT : HOPPER_CYCLES;
    localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0] MOTOR_LAST = TW'(MOTOR_TIMEOUT - 1);
    localparam logic [TW-1:0] HOP_LAST   = TW'(HOPPER_CYCLES - 1);
    localparam logic [AW:0]   ONE_LEFT   = (AW+1)'(1);

    vend_state_t        r_state;
    vend_state_t        w_state_nxt;
    logic [TW-1:0]      r_timer;
    logic [TW-1:0]      w_timer_nxt;
    logic [EVT_W-1:0]   r_entry;
    logic [EVT_W-1:0]   w_entry_nxt;

    logic               r_motor_en;
    logic               r_hopper5;
    logic               r_hopper10;
    logic               r_busy;
    logic               r_overflow;
    logic               r_fault;
    logic [CNT_W-1:0]   r_sales_cnt;

    logic [EVT_W-1:0]   w_evt;
    logic               w_evt_any;
    logic               w_push_acc;
    logic               w_drop;
    logic               w_pop;
    logic               w_sale;
    logic               w_full;
    logic               w_empty;
    logic               w_nonempty_nxt;
    logic [EVT_W-1:0]   w_head;
    logic [AW:0]        w_count;

    always_comb begin
        w_evt          = '0;
        w_evt[EVT_OUT] = out;
        w_evt[EVT_C10] = change10;
        w_evt[EVT_C5]  = change5;
    end

    // A push into a full FIFO still succeeds when the head leaves this cycle.
    assign w_evt_any  = |w_evt;
    assign w_push_acc = w_evt_any & (~w_full | w_pop);
    assign w_drop     = w_evt_any & ~w_push_acc;

    vend_evt_fifo #(
        .DEPTH (QDEPTH),
        .W     (EVT_W)
    ) u_fifo (
        .clk     (clk),
        .i_rst_n (rst),
        .i_push  (w_push_acc),
        .i_wdata (w_evt),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_nonempty_nxt = w_push_acc | (~w_empty & ~(w_pop & (w_count == ONE_LEFT)));

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_entry_nxt = r_entry;
        w_pop       = 1'b0;
        w_sale      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_entry_nxt = w_head;
                    w_timer_nxt = '0;
                    w_state_nxt = first_state(w_head);
                end
            end
            ST_VEND: begin
                // Done wins over timeout when both occur on the last allowed cycle.
                if (motor_done) begin
                    w_sale      = 1'b1;
                    w_timer_nxt = '0;
                    w_state_nxt = after_vend(r_entry);
                end else if (r_timer == MOTOR_LAST) begin
                    w_timer_nxt = '0;
                    w_state_nxt = ST_FAULT;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            ST_CHG10: begin
                if (r_timer == HOP_LAST) begin
                    w_timer_nxt = '0;
                    w_state_nxt = r_entry[EVT_C5] ? ST_CHG5 : ST_IDLE;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            ST_CHG5: begin
                if (r_timer == HOP_LAST) begin
                    w_timer_nxt = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            ST_FAULT: begin
                w_state_nxt = ST_FAULT;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
            r_entry <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_entry <= w_entry_nxt;
        end
    end

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_motor_en  <= 1'b0;
            r_hopper5   <= 1'b0;
            r_hopper10  <= 1'b0;
            r_busy      <= 1'b0;
            r_overflow  <= 1'b0;
            r_fault     <= 1'b0;
            r_sales_cnt <= '0;
        end else begin
            r_motor_en  <= (w_state_nxt == ST_VEND);
            r_hopper5   <= (w_state_nxt == ST_CHG5);
            r_hopper10  <= (w_state_nxt == ST_CHG10);
            r_busy      <= (w_state_nxt != ST_IDLE) | w_nonempty_nxt;
            r_overflow  <= r_overflow | w_drop;
            r_fault     <= r_fault | (w_state_nxt == ST_FAULT);
            if (w_sale) begin
                r_sales_cnt <= r_sales_cnt + 1'b1;
            end
        end
    end

    assign motor_en  = r_motor_en;
    assign hopper5   = r_hopper5;
    assign hopper10  = r_hopper10;
    assign busy      = r_busy;
    assign overflow  = r_overflow;
    assign fault     = r_fault;
    assign sales_cnt = r_sales_cnt;
    assign dbg_state = r_state;

endmodule
